// File: rtl/box3x3_sum_pkg.sv
// Shared types and width helpers for the 3x3 neighbourhood-sum stage.
// Widths derive from module parameters, so they are exposed as constant functions.
package box3x3_sum_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Per-pixel tags carried alongside the data through the pipeline.
    typedef struct packed {
        logic valid;  // stage holds an accepted pixel
        logic emit;   // pixel completes a full 3x3 window (row>=2, col>=2)
        logic sof;    // first window of the frame
        logic eof;    // last window of the frame
    } tag_t;

    // Nine DW-bit values: 9*(2^DW-1) < 2^(DW+4).
    function automatic int sum_width(input int dw);
        return dw + 4;
    endfunction

    // Three DW-bit values: 3*(2^DW-1) < 2^(DW+2).
    function automatic int colsum_width(input int dw);
        return dw + 2;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/box3x3_sum_line_buf_sdp.sv
// Simple dual-port line buffer with registered read; a read and write to the
// same address in one cycle returns the old contents.
module line_buf_sdp
    import box3x3_sum_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = 16,
    parameter int AW    = cnt_width(DEPTH)
) (
    input  logic             i_Sys_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    // No reset here so the array maps onto block RAM; contents are don't-care.
    always_ff @(posedge i_Sys_clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_reg[rd_addr];
        end
    end

endmodule

// File: rtl/box3x3_sum.sv
// Streaming 3x3 window sum over a raster pixel stream with two line buffers.
// Fixed two-cycle latency from accepting edge to registered output.
module box3x3_sum
    import box3x3_sum_pkg::*;
#(
    parameter int DW           = 16,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 512
) (
    input  logic                     i_Sys_clk,
    input  logic                     i_Rst_n,
    input  logic                     i_Valid,
    input  logic                     i_Sof,
    input  logic [DW-1:0]            i_Din,
    output logic                     o_Valid,
    output logic                     o_Sof,
    output logic                     o_Eof,
    output logic [sum_width(DW)-1:0] o_Sum
);

    localparam int SW  = sum_width(DW);
    localparam int CSW = colsum_width(DW);
    localparam int CW  = cnt_width(IMAGE_WIDTH);
    localparam int RW  = cnt_width(IMAGE_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_t          state_reg;
    logic [CW-1:0]   col_reg;
    logic [RW-1:0]   row_reg;

    logic            accept;
    logic            restart;
    logic [CW-1:0]   pix_col;
    logic [RW-1:0]   pix_row;
    tag_t            pix_tag;

    tag_t            s0_tag_reg;
    logic [CW-1:0]   s0_col_reg;
    logic [DW-1:0]   s0_din_reg;

    tag_t            s1_tag_reg;
    logic [CSW-1:0]  s1_colsum_reg;

    logic [CSW-1:0]  win_reg [2];

    logic [1:0]           lb_we;
    logic [1:0][CW-1:0]   lb_waddr;
    logic [1:0][DW-1:0]   lb_wdata;
    logic [1:0][DW-1:0]   lb_rdata;

    // Position of the pixel on the bus; i_Sof forces (0,0) in either state.
    always_comb begin
        accept  = i_Valid && ((state_reg == ACTIVE) || i_Sof);
        restart = accept && i_Sof && (state_reg == ACTIVE);
        pix_col = col_reg;
        pix_row = row_reg;
        if (i_Sof) begin
            pix_col = '0;
            pix_row = '0;
        end
        pix_tag.valid = accept;
        pix_tag.emit  = (pix_row >= ROW_TWO) && (pix_col >= COL_TWO);
        pix_tag.sof   = (pix_row == ROW_TWO) && (pix_col == COL_TWO);
        pix_tag.eof   = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
    end

    always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
        end else if (accept) begin
            if (pix_tag.eof) begin
                state_reg <= IDLE;
                col_reg   <= '0;
                row_reg   <= '0;
            end else begin
                state_reg <= ACTIVE;
                if (pix_col == COL_LAST) begin
                    col_reg <= '0;
                    row_reg <= pix_row + 1'b1;
                end else begin
                    col_reg <= pix_col + 1'b1;
                    row_reg <= pix_row;
                end
            end
        end
    end

    // LB0 is refreshed on the accept itself; LB1 takes the old LB0 word one
    // cycle later, once the registered read has brought it out of the RAM.
    always_comb begin
        lb_we[0]    = accept;
        lb_waddr[0] = pix_col;
        lb_wdata[0] = i_Din;
        lb_we[1]    = s0_tag_reg.valid;
        lb_waddr[1] = s0_col_reg;
        lb_wdata[1] = lb_rdata[0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lb
            line_buf_sdp #(
                .DEPTH (IMAGE_WIDTH),
                .WIDTH (DW),
                .AW    (CW)
            ) u_lb (
                .i_Sys_clk (i_Sys_clk),
                .wr_en     (lb_we[gi]),
                .wr_addr   (lb_waddr[gi]),
                .wr_data   (lb_wdata[gi]),
                .rd_en     (accept),
                .rd_addr   (pix_col),
                .rd_data   (lb_rdata[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            s0_tag_reg <= '0;
            s0_col_reg <= '0;
            s0_din_reg <= '0;
        end else begin
            s0_tag_reg <= pix_tag;
            if (accept) begin
                s0_col_reg <= pix_col;
                s0_din_reg <= i_Din;
            end
        end
    end

    // A restart squashes old-frame pixels still in flight.
    always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            s1_tag_reg    <= '0;
            s1_colsum_reg <= '0;
        end else begin
            s1_tag_reg <= restart ? '0 : s0_tag_reg;
            if (s0_tag_reg.valid) begin
                s1_colsum_reg <= CSW'(s0_din_reg) + CSW'(lb_rdata[0]) + CSW'(lb_rdata[1]);
            end
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_win
            if (gi == 0) begin : g_head
                always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
                    if (!i_Rst_n) begin
                        win_reg[gi] <= '0;
                    end else if (s1_tag_reg.valid) begin
                        win_reg[gi] <= s1_colsum_reg;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
                    if (!i_Rst_n) begin
                        win_reg[gi] <= '0;
                    end else if (s1_tag_reg.valid) begin
                        win_reg[gi] <= win_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Valid <= 1'b0;
            o_Sof   <= 1'b0;
            o_Eof   <= 1'b0;
            o_Sum   <= '0;
        end else if (!restart && s1_tag_reg.valid && s1_tag_reg.emit) begin
            o_Valid <= 1'b1;
            o_Sof   <= s1_tag_reg.sof;
            o_Eof   <= s1_tag_reg.eof;
            o_Sum   <= SW'(s1_colsum_reg) + SW'(win_reg[0]) + SW'(win_reg[1]);
        end else begin
            o_Valid <= 1'b0;
            o_Sof   <= 1'b0;
            o_Eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_box3x3_sum.sv
// Self-checking bench for box3x3_sum on an 8x6 frame: a window-sum model over
// a stored image predicts every output cycle, plus literal frame-level checks.
module tb_box3x3_sum;

    localparam int DW = 16;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int SW = DW + 4;

    logic          clk;
    logic          rst_n;
    logic          i_Valid;
    logic          i_Sof;
    logic [DW-1:0] i_Din;
    logic          o_Valid;
    logic          o_Sof;
    logic          o_Eof;
    logic [SW-1:0] o_Sum;

    box3x3_sum #(
        .DW           (DW),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .i_Sys_clk (clk),
        .i_Rst_n   (rst_n),
        .i_Valid   (i_Valid),
        .i_Sof     (i_Sof),
        .i_Din     (i_Din),
        .o_Valid   (o_Valid),
        .o_Sof     (o_Sof),
        .o_Eof     (o_Eof),
        .o_Sum     (o_Sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    int            cyc = 0;
    bit            m_active = 0;
    int            mr = 0;
    int            mc = 0;
    int            img [H][W];
    bit            exp_v   [int];
    logic [SW-1:0] exp_sum [int];
    bit            exp_sof [int];
    bit            exp_eof [int];

    always @(posedge clk or negedge rst_n) begin : model
        int s;
        if (!rst_n) begin
            m_active = 0;
            mr = 0;
            mc = 0;
            exp_v.delete();
        end else begin
            cyc++;
            if (i_Valid && (m_active || i_Sof)) begin
                if (i_Sof) begin
                    // Old-frame results due now or next cycle are discarded.
                    if (m_active) begin
                        exp_v.delete(cyc);
                        exp_v.delete(cyc + 1);
                    end
                    mr = 0;
                    mc = 0;
                end
                img[mr][mc] = int'(i_Din);
                if (mr >= 2 && mc >= 2) begin
                    s = 0;
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            s += img[mr-dr][mc-dc];
                    exp_v[cyc+2]   = 1'b1;
                    exp_sum[cyc+2] = SW'(s);
                    exp_sof[cyc+2] = (mr == 2 && mc == 2);
                    exp_eof[cyc+2] = (mr == H-1 && mc == W-1);
                end
                if (mr == H-1 && mc == W-1) begin
                    m_active = 0;
                    mr = 0;
                    mc = 0;
                end else begin
                    m_active = 1;
                    if (mc == W-1) begin
                        mc = 0;
                        mr++;
                    end else begin
                        mc++;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [SW-1:0] last_sum = '0;
    int cap_sum [$];
    bit cap_sof [$];
    bit cap_eof [$];

    always @(negedge clk) begin : compare
        logic [31:0] act;
        logic [31:0] expv;
        act = {9'd0, o_Valid, o_Sof, o_Eof, o_Sum};
        if (!rst_n) begin
            last_sum = '0;
            expv = '0;
        end else if (exp_v.exists(cyc)) begin
            expv = {9'd0, 1'b1, exp_sof[cyc], exp_eof[cyc], exp_sum[cyc]};
            last_sum = exp_sum[cyc];
        end else begin
            expv = {9'd0, 3'b000, last_sum};
        end
        chk("cycle{valid,sof,eof,sum}", act, expv);
        if (o_Valid === 1'b1) begin
            cap_sum.push_back(int'(o_Sum));
            cap_sof.push_back(o_Sof);
            cap_eof.push_back(o_Eof);
            $display("out cyc=%0d sum=%0d sof=%0b eof=%0b", cyc, o_Sum, o_Sof, o_Eof);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [DW-1:0] pix(input int mode, input int r, input int c);
        case (mode)
            0:       return 16'd100;
            1:       return DW'(r * W + c);
            2:       return 16'hFFFF;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_Valid = 1'b0;
            i_Sof   = 1'b0;
        end
    endtask

    // Sends pixels in raster order, stopping before (stop_r, stop_c).
    task automatic frame(input int mode, input int gap, input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                while ($urandom_range(0, 99) < gap) idle(1);
                @(negedge clk);
                i_Valid = 1'b1;
                i_Sof   = (r == 0 && c == 0);
                i_Din   = pix(mode, r, c);
            end
        end
    endtask

    task automatic clear_cap();
        cap_sum.delete();
        cap_sof.delete();
        cap_eof.delete();
    endtask

    function automatic int count_bits(input bit q [$]);
        int n = 0;
        foreach (q[i]) n += q[i];
        return n;
    endfunction

    // Ramp window ending at (r,c) sums to 9 * pixel(r-1,c-1).
    task automatic check_ramp(input string name, input int offset);
        for (int k = 0; k < (H-2)*(W-2); k++) begin
            chk(name, cap_sum[offset+k], 9 * ((2 + k/(W-2) - 1) * W + (2 + k%(W-2) - 1)));
        end
    endtask

    initial begin
        i_Valid = 1'b0;
        i_Sof   = 1'b0;
        i_Din   = '0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_valid", {31'd0, o_Valid}, 32'd0);
        chk("reset_sum", {12'd0, o_Sum}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Constant 100
        clear_cap();
        frame(0, 0, -1, -1);
        idle(6);
        chk("const_count", cap_sum.size(), 24);
        foreach (cap_sum[i]) chk("const_sum", cap_sum[i], 900);
        chk("const_sof_first", {31'd0, cap_sof[0]}, 32'd1);
        chk("const_eof_last", {31'd0, cap_eof[23]}, 32'd1);
        chk("const_sof_count", count_bits(cap_sof), 1);
        chk("const_eof_count", count_bits(cap_eof), 1);

        // Ramp, continuous
        clear_cap();
        frame(1, 0, -1, -1);
        idle(6);
        chk("ramp_count", cap_sum.size(), 24);
        chk("ramp_first", cap_sum[0], 81);
        chk("ramp_last", cap_sum[23], 342);
        check_ramp("ramp_seq", 0);

        // Full-scale pixels
        clear_cap();
        frame(2, 0, -1, -1);
        idle(6);
        chk("max_count", cap_sum.size(), 24);
        foreach (cap_sum[i]) chk("max_sum", cap_sum[i], 32'h8FFF7);

        // Ramp with ~40% idle cycles
        clear_cap();
        frame(1, 40, -1, -1);
        idle(6);
        chk("gap_count", cap_sum.size(), 24);
        check_ramp("gap_seq", 0);

        // Restart at (3,4): (3,2) and (3,3) are in flight and must be dropped
        clear_cap();
        frame(1, 0, 3, 4);
        frame(1, 0, -1, -1);
        idle(6);
        chk("abort_count", cap_sum.size(), 6 + 24);
        chk("abort_eof_count", count_bits(cap_eof), 1);
        chk("abort_sof_count", count_bits(cap_sof), 2);
        check_ramp("abort_seq", 6);

        // Asynchronous reset mid-frame
        frame(0, 0, 4, 5);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, o_Valid}, 32'd0);
        chk("async_rst_sof", {31'd0, o_Sof}, 32'd0);
        chk("async_rst_eof", {31'd0, o_Eof}, 32'd0);
        chk("async_rst_sum", {12'd0, o_Sum}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        clear_cap();
        repeat (12) begin
            @(negedge clk);
            i_Valid = 1'b1;
            i_Sof   = 1'b0;
            i_Din   = DW'($urandom);
        end
        idle(4);
        chk("post_rst_silent", cap_sum.size(), 0);
        frame(1, 0, -1, -1);
        idle(6);
        chk("post_rst_count", cap_sum.size(), 24);
        check_ramp("post_rst_seq", 0);

        // Random pixels with gaps, back-to-back frames
        clear_cap();
        frame(3, 30, -1, -1);
        frame(3, 0, -1, -1);
        idle(6);
        chk("rand_count", cap_sum.size(), 48);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
